// File: rtl/io_out_fifo_if.sv
`default_nettype none
// =============================================================================
// Module   : io_out_fifo_if
// Brief    : CPU I/O strobes and consumer handshake for io_out_fifo.
// Revision : 1.0  initial release
// =============================================================================
interface io_out_fifo_if;
  logic [3:0] io_addr;
  logic       io_oe;
  logic       io_we;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       ovf;

  modport master (
    output io_addr, io_oe, io_we, out_ready,
    input  out_data, out_valid, ovf
  );

  modport slave (
    input  io_addr, io_oe, io_we, out_ready,
    output out_data, out_valid, ovf
  );
endinterface
`default_nettype wire

// File: rtl/io_out_fifo.sv
`default_nettype none
// =============================================================================
// Module   : io_out_fifo
// Brief    : I/O-bus output FIFO with valid/ready drain and status register.
//            Optional head peek at BASE_ADDR: IO_OUT_FIFO_PEEK_EN.
// Revision : 1.0  initial release
// =============================================================================
module io_out_fifo #(
  parameter logic [3:0] BASE_ADDR = 4'h0,
  parameter int         DEPTH     = 8
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire  [7:0] io_data,
  io_out_fifo_if.slave bus
);

  localparam int         c_AW        = $clog2(DEPTH);
  localparam logic [3:0] c_STAT_ADDR = BASE_ADDR + 4'd1;
  localparam logic [c_AW:0] c_PTR_ONE = (c_AW+1)'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [c_AW:0] r_wr_ptr;
  logic [c_AW:0] r_rd_ptr;
  logic          r_ovf;

  logic [c_AW:0] w_count;
  logic [3:0]    w_count4;
  logic          w_empty;
  logic          w_full;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_stat_wr;
  logic          w_flush;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic          w_stat_rd;
  logic          w_peek_rd;
  logic [7:0]    w_head;
  logic [7:0]    w_status;
  logic [7:0]    w_rd_data;

  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_count4 = 4'(w_count);
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                    (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);

  assign w_push_req = bus.io_we && (bus.io_addr == BASE_ADDR);
  assign w_stat_wr  = bus.io_we && (bus.io_addr == c_STAT_ADDR);
  assign w_pop      = !w_empty && bus.out_ready;
  assign w_flush    = w_stat_wr && io_data[7];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = w_stat_wr && io_data[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_ovf <= 1'b0;
    else if (w_ovf_clr) r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
  end

  // Storage is deliberately not reset; emptiness gates what is visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= io_data;
  end

  assign w_head   = w_empty ? 8'h00 : r_mem[r_rd_ptr[c_AW-1:0]];
  assign w_status = {w_count4, 1'b0, r_ovf, w_full, w_empty};

  assign w_stat_rd = bus.io_oe && !bus.io_we && (bus.io_addr == c_STAT_ADDR);
`ifdef IO_OUT_FIFO_PEEK_EN
  assign w_peek_rd = bus.io_oe && !bus.io_we && (bus.io_addr == BASE_ADDR);
`else
  assign w_peek_rd = 1'b0;
`endif

  assign w_rd_data = w_peek_rd ? w_head : w_status;
  assign io_data   = (w_stat_rd || w_peek_rd) ? w_rd_data : 8'hzz;

  assign bus.out_data  = w_head;
  assign bus.out_valid = !w_empty;
  assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_io_out_fifo.sv
`default_nettype none
// =============================================================================
// Module   : tb_io_out_fifo
// Brief    : Directed plus random checks of io_out_fifo against a queue model.
// Revision : 1.0  initial release
// =============================================================================
module tb_io_out_fifo;

  localparam int c_DEPTH = 8;

  logic       clk;
  logic       reset;
  logic       cpu_en;
  logic [7:0] cpu_drv;
  wire  [7:0] io_data;
  logic [7:0] bus_rd;

  int checks;
  int errors;

  logic [7:0] m_q[$];
  logic       m_ovf;

  io_out_fifo_if bus ();

  assign io_data = cpu_en ? cpu_drv : 8'hzz;

  io_out_fifo #(.BASE_ADDR(4'h0), .DEPTH(c_DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .io_data (io_data),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    int n;
    logic [3:0] c;
    n = m_q.size();
    c = 4'(n);
    return {c, 1'b0, m_ovf, (n == c_DEPTH), (n == 0)};
  endfunction

  function automatic logic [7:0] m_head();
    return (m_q.size() > 0) ? m_q[0] : 8'h00;
  endfunction

  task automatic check_outputs();
    check("out_valid", {7'd0, bus.out_valid}, {7'd0, (m_q.size() > 0)});
    check("out_data", bus.out_data, m_head());
    check("ovf", {7'd0, bus.ovf}, {7'd0, m_ovf});
  endtask

  // Rule-level model of one clock edge.
  task automatic model_edge(input logic we, input logic [3:0] addr,
                            input logic [7:0] data, input logic rdy);
    logic pop;
    logic was_full;
    pop      = (m_q.size() > 0) && rdy;
    was_full = (m_q.size() == c_DEPTH);
    if (we && addr == 4'h1 && data[7]) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (we && addr == 4'h0) begin
        if (!was_full || pop) m_q.push_back(data);
        else                  m_ovf = 1'b1;
      end
    end
    if (we && addr == 4'h1 && data[2]) m_ovf = 1'b0;
  endtask

  // Called at a negedge; checks pre-edge outputs, then advances one cycle.
  task automatic drive(input logic we, input logic oe, input logic [3:0] addr,
                       input logic [7:0] data, input logic rdy);
    bus.io_we     = we;
    bus.io_oe     = oe;
    bus.io_addr   = addr;
    bus.out_ready = rdy;
    cpu_drv       = data;
    cpu_en        = we;
    #1;
    check_outputs();
    bus_rd = io_data;
    if (oe && !we && addr == 4'h1) check("status_rd", bus_rd, m_status());
`ifdef IO_OUT_FIFO_PEEK_EN
    if (oe && !we && addr == 4'h0) check("peek_rd", bus_rd, m_head());
`endif
    @(posedge clk);
    model_edge(we, addr, data, rdy);
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d, input logic rdy);
    drive(1'b1, 1'b0, 4'h0, d, rdy);
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, 4'h5, 8'h00, rdy);
  endtask

  task automatic rd_status();
    drive(1'b0, 1'b1, 4'h1, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] exp3 [3];
    checks = 0;
    errors = 0;
    m_ovf  = 1'b0;
    exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
    reset = 1'b1;
    cpu_en = 1'b0; cpu_drv = 8'h00;
    bus.io_we = 1'b0; bus.io_oe = 1'b1; bus.io_addr = 4'h1; bus.out_ready = 1'b0;
    #12;
    check_outputs();
    check("reset_status", io_data, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Three bytes, no consumer.
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0);
    rd_status();
    check("status_3", bus_rd, 8'h30);
    check("head_11", bus.out_data, 8'h11);

    // Drain on consecutive cycles.
    for (int i = 0; i < 3; i++) begin
      #0 check("drain_seq", bus.out_data, exp3[i]);
      idle(1'b1);
    end
    rd_status();
    check("status_empty", bus_rd, 8'h01);

    // Overflow: nine pushes into eight slots.
    for (int i = 1; i <= 9; i++) push(8'(i), 1'b0);
    rd_status();
    check("status_ovf", bus_rd, 8'h86);
    check("ovf_pin", {7'd0, bus.ovf}, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      check("drain_ovf", bus.out_data, 8'(i));
      idle(1'b1);
    end
    drive(1'b1, 1'b0, 4'h1, 8'h04, 1'b0);
    rd_status();
    check("status_ovf_clr", bus_rd, 8'h01);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i), 1'b0);
    push(8'hAA, 1'b1);
    rd_status();
    check("status_full_pp", bus_rd, 8'h82);
    for (int i = 0; i < 8; i++) idle(1'b1);
    rd_status();

    // Flush.
    push(8'hC1, 1'b0); push(8'hC2, 1'b0); push(8'hC3, 1'b0);
    drive(1'b1, 1'b0, 4'h1, 8'h80, 1'b0);
    rd_status();
    check("status_flush", bus_rd, 8'h01);

    // Empty FIFO: push with out_ready high must not pop.
    push(8'h5C, 1'b1);
    check("empty_push_rdy", bus.out_data, 8'h5C);
    idle(1'b1);

    // Asynchronous reset between edges.
    for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i), 1'b0);
    bus.io_we = 1'b0; bus.io_oe = 1'b1; bus.io_addr = 4'h1; cpu_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    m_q.delete();
    m_ovf = 1'b0;
    check("async_valid", {7'd0, bus.out_valid}, 8'h00);
    check("async_status", io_data, 8'h01);
`ifdef IO_OUT_FIFO_PEEK_EN
    bus.io_addr = 4'h0;
    #1 check("async_peek", io_data, 8'h00);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      int op;
      logic [7:0] d;
      logic r;
      op = $urandom_range(0, 9);
      d  = 8'($urandom);
      r  = ($urandom_range(0, 2) == 0);
      case (op)
        0, 1, 2, 3: push(d, r);
        4: begin
          if ($urandom_range(0, 7) != 0) d[7] = 1'b0;
          drive(1'b1, 1'b0, 4'h1, d, r);
        end
        5, 6: drive(1'b0, 1'b1, 4'h1, 8'h00, r);
        7: drive(1'b0, 1'b1, 4'h0, 8'h00, r);
        8: drive(1'b1, 1'b1, 4'h0, d, r);
        default: drive(1'b1, 1'b0, 4'($urandom_range(2, 15)), d, r);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
